// File: rtl/bcd_7seg_scan.sv
// ============================================================================
// Module   : bcd_7seg_scan
// Brief    : Time-multiplexed BCD to 7-segment scanner. It drives an active-low
//            segment bus and active-low one-hot digit enables. The BCD input is
//            snapshotted at each frame start so a frame never tears.
//            Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_7seg_scan #(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [4*DIGITS-1:0] bcd,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame
);

    localparam int C_CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int C_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(PRESCALE - 1);
    localparam logic [C_IW-1:0] C_IDX_LAST = C_IW'(DIGITS - 1);
    localparam logic [6:0]      C_BLANK    = 7'h7F;
    localparam logic [6:0]      C_DASH     = 7'h3F;

    logic [C_CW-1:0]     r_cnt;
    logic [C_IW-1:0]     r_idx;
    logic [4*DIGITS-1:0] r_shadow;

    logic                w_tick;
    logic                w_frame_start;
    logic [C_IW-1:0]     w_nidx;
    logic [4*DIGITS-1:0] w_src;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_an;
    logic [6:0]          w_seg;
    logic                w_blank;

    // Active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'd0:    v = 7'h40;
            4'd1:    v = 7'h79;
            4'd2:    v = 7'h24;
            4'd3:    v = 7'h30;
            4'd4:    v = 7'h19;
            4'd5:    v = 7'h12;
            4'd6:    v = 7'h02;
            4'd7:    v = 7'h78;
            4'd8:    v = 7'h00;
            4'd9:    v = 7'h10;
            default: v = C_DASH;
        endcase
        return v;
    endfunction

    assign w_tick        = en && (r_cnt == C_CNT_LAST);
    assign w_nidx        = (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IW'(1);
    assign w_frame_start = w_tick && (w_nidx == '0);

    // At frame start the fresh input is shown immediately rather than the stale shadow.
    assign w_src = (w_nidx == '0) ? bcd : r_shadow;

    always_comb begin
        w_nib = 4'h0;
        w_an  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_nidx == C_IW'(k)) begin
                w_nib   = w_src[4*k +: 4];
                w_an[k] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // w_hz[k]: nibble k and every more significant nibble are zero.
    logic [DIGITS:0] w_hz;
    assign w_hz[DIGITS] = 1'b1;

    for (genvar k = DIGITS - 1; k >= 0; k--) begin : g_hz
        assign w_hz[k] = (w_src[4*k +: 4] == 4'h0) && w_hz[k+1];
    end

    always_comb begin
        w_blank = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (w_nidx == C_IW'(k)) begin
                w_blank = w_hz[k];
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg = w_blank ? C_BLANK : f_decode(w_nib);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= C_IDX_LAST;
            r_shadow <= '0;
            seg      <= C_BLANK;
            an       <= '1;
            frame    <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= w_nidx;
                an    <= w_an;
                seg   <= w_seg;
                if (w_frame_start) begin
                    r_shadow <= bcd;
                    frame    <= 1'b1;
                end
            end else if (en) begin
                r_cnt <= r_cnt + C_CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_7seg_scan.sv
// ============================================================================
// Module   : tb_bcd_7seg_scan
// Brief    : Directed self-checking bench for bcd_7seg_scan (DIGITS=3, PRESCALE=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_7seg_scan;

    localparam int DIGITS   = 3;
    localparam int PRESCALE = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] C_LZ = 7'h7F;
`else
    localparam logic [6:0] C_LZ = 7'h40;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [11:0]       bcd;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              frame;

    int checks = 0;
    int errors = 0;

    bcd_7seg_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .bcd   (bcd),
        .seg   (seg),
        .an    (an),
        .frame (frame)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, returning on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [6:0] es,
                       input logic [2:0] ea, input logic ef);
        checks++;
        assert (seg === es) else begin
            errors++;
            $error("FAIL %s seg got %h exp %h", tag, seg, es);
        end
        checks++;
        assert (an === ea) else begin
            errors++;
            $error("FAIL %s an got %b exp %b", tag, an, ea);
        end
        checks++;
        assert (frame === ef) else begin
            errors++;
            $error("FAIL %s frame got %b exp %b", tag, frame, ef);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        bcd = 12'h000;
        @(negedge clk);
        cyc(2);
        chk("reset", 7'h7F, 3'b111, 1'b0);

        // Case 1: dark until the first tick
        rst = 1'b0;
        en  = 1'b1;
        bcd = 12'h255;
        cyc(1); chk("dark1", 7'h7F, 3'b111, 1'b0);
        cyc(2); chk("dark3", 7'h7F, 3'b111, 1'b0);

        // Case 2: scan 255
        cyc(1); chk("f1_d0", 7'h12, 3'b110, 1'b1);
        cyc(1); chk("f1_d0_hold", 7'h12, 3'b110, 1'b0);
        cyc(3); chk("f1_d1", 7'h12, 3'b101, 1'b0);

        // Case 3: mid-frame change is invisible until the next frame
        cyc(1); bcd = 12'h128;
        cyc(3); chk("f1_d2", 7'h24, 3'b011, 1'b0);
        cyc(4); chk("f2_d0", 7'h00, 3'b110, 1'b1);
        cyc(4); chk("f2_d1", 7'h24, 3'b101, 1'b0);
        cyc(4); chk("f2_d2", 7'h79, 3'b011, 1'b0);

        // Case 4: freeze mid-slot
        cyc(1); en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1); chk("frozen", 7'h79, 3'b011, 1'b0);
        end
        en = 1'b1;
        cyc(2); chk("resume", 7'h79, 3'b011, 1'b0);
        cyc(1); chk("f3_d0", 7'h00, 3'b110, 1'b1);

        // Case 5: dash and leading zero
        bcd = 12'h0A3;
        cyc(4); chk("f3_d1", 7'h24, 3'b101, 1'b0);
        cyc(4); chk("f3_d2", 7'h79, 3'b011, 1'b0);
        cyc(4); chk("f4_d0", 7'h30, 3'b110, 1'b1);
        cyc(4); chk("f4_dash", 7'h3F, 3'b101, 1'b0);
        cyc(4); chk("f4_lz", C_LZ, 3'b011, 1'b0);

        // Case 6: two leading zeros
        bcd = 12'h007;
        cyc(4); chk("f5_d0", 7'h78, 3'b110, 1'b1);
        cyc(4); chk("f5_d1", C_LZ, 3'b101, 1'b0);
        cyc(4); chk("f5_d2", C_LZ, 3'b011, 1'b0);

        // Reset mid-slot
        cyc(1); rst = 1'b1;
        cyc(1); chk("rst_mid", 7'h7F, 3'b111, 1'b0);
        rst = 1'b0;
        cyc(3); chk("post_rst_dark", 7'h7F, 3'b111, 1'b0);
        cyc(1); chk("post_rst_d0", 7'h78, 3'b110, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
